// File: rtl/tile_map_arbiter.sv
// Shares a single-port tile-map RAM between the VGA renderer (absolute priority) and a
// req/ack game-logic port. Optional macro BLANK_ONLY_WR_EN restricts game writes to blanking.
module tile_map_arbiter #(
    parameter int unsigned TILE_SHIFT = 5,
    parameter int unsigned MAP_W      = 20,
    parameter int unsigned MAP_H      = 15,
    parameter int unsigned AW         = 9,
    parameter int unsigned TW         = 4,
    parameter int unsigned MAX_WAIT   = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_tick,
    input  logic          display_on,
    input  logic [9:0]    x_pos,
    input  logic [9:0]    y_pos,
    output logic [TW-1:0] tile_q,
    output logic          tile_vld,
    input  logic          gl_req,
    input  logic          gl_we,
    input  logic [AW-1:0] gl_addr,
    input  logic [TW-1:0] gl_wdata,
    output logic          gl_ack,
    output logic [TW-1:0] gl_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [TW-1:0] mem_wdata,
    input  logic [TW-1:0] mem_rdata,
    output logic [1:0]    err
);

    localparam int unsigned XW    = 10 - TILE_SHIFT;
    localparam int unsigned CELLS = MAP_W * MAP_H;
    localparam int unsigned WCW   = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, ACK} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [TW-1:0] mem_wdata_q, mem_wdata_d;
    logic [TW-1:0] tile_q_q, tile_q_d;
    logic          tile_vld_q, tile_vld_d;
    logic          gl_ack_q, gl_ack_d;
    logic [TW-1:0] gl_rdata_q, gl_rdata_d;
    logic [1:0]    err_q, err_d;
    logic [WCW-1:0] wait_q, wait_d;
    // Owner-tag pipeline: stage 0 aligns with mem_addr, stage 1 with mem_rdata.
    logic          tag0_vld_q, tag0_vld_d, tag0_gl_q, tag0_gl_d;
    logic          tag1_vld_q, tag1_gl_q;

    logic [XW-1:0] tile_x_c, tile_y_c;
    logic [AW-1:0] render_idx_c;
    logic          slot_c, bad_addr_c, wr_block_c, game_want_c;

    assign tile_x_c     = x_pos[9:TILE_SHIFT];
    assign tile_y_c     = y_pos[9:TILE_SHIFT];
    assign slot_c       = p_tick && display_on && (32'(tile_x_c) < MAP_W) && (32'(tile_y_c) < MAP_H);
    assign render_idx_c = AW'(32'(tile_y_c) * MAP_W + 32'(tile_x_c));
    assign bad_addr_c   = 32'(gl_addr) >= CELLS;
    // The ack cycle itself never starts a new access, forcing one idle cycle between requests.
    assign game_want_c  = (state_q == IDLE) && gl_req && !gl_ack_q;

`ifdef BLANK_ONLY_WR_EN
    assign wr_block_c = gl_we && display_on;
`else
    assign wr_block_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            tile_q_q    <= '0;
            tile_vld_q  <= 1'b0;
            gl_ack_q    <= 1'b0;
            gl_rdata_q  <= '0;
            err_q       <= '0;
            wait_q      <= '0;
            tag0_vld_q  <= 1'b0;
            tag0_gl_q   <= 1'b0;
            tag1_vld_q  <= 1'b0;
            tag1_gl_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            tile_q_q    <= tile_q_d;
            tile_vld_q  <= tile_vld_d;
            gl_ack_q    <= gl_ack_d;
            gl_rdata_q  <= gl_rdata_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
            tag0_vld_q  <= tag0_vld_d;
            tag0_gl_q   <= tag0_gl_d;
            tag1_vld_q  <= tag0_vld_q;
            tag1_gl_q   <= tag0_gl_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        tile_q_d    = tile_q_q;
        tile_vld_d  = 1'b0;
        gl_ack_d    = 1'b0;
        gl_rdata_d  = gl_rdata_q;
        err_d       = err_q;
        wait_d      = wait_q;
        tag0_vld_d  = 1'b0;
        tag0_gl_d   = 1'b0;

        // Route returning RAM data by owner tag.
        if (tag1_vld_q) begin
            if (tag1_gl_q) begin
                gl_rdata_d = mem_rdata;
                gl_ack_d   = 1'b1;
            end else begin
                tile_q_d   = mem_rdata;
                tile_vld_d = 1'b1;
            end
        end

        if (slot_c) begin
            mem_addr_d = render_idx_c;
            tag0_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (game_want_c) begin
                    if (slot_c || (wr_block_c && !bad_addr_c)) begin
                        if (wait_q != WCW'(MAX_WAIT)) begin
                            wait_d = wait_q + 1'b1;
                        end
                        if (wait_d == WCW'(MAX_WAIT)) begin
                            err_d[0] = 1'b1;
                        end
                    end else if (bad_addr_c) begin
                        gl_ack_d   = 1'b1;
                        gl_rdata_d = '0;
                        err_d[1]   = 1'b1;
                        wait_d     = '0;
                    end else begin
                        mem_addr_d  = gl_addr;
                        mem_we_d    = gl_we;
                        mem_wdata_d = gl_wdata;
                        wait_d      = '0;
                        if (gl_we) begin
                            state_d = ACK;
                        end else begin
                            tag0_vld_d = 1'b1;
                            tag0_gl_d  = 1'b1;
                            state_d    = RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (tag1_vld_q && tag1_gl_q) begin
                    state_d = IDLE;
                end
            end
            ACK: begin
                gl_ack_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tile_q    = tile_q_q;
    assign tile_vld  = tile_vld_q;
    assign gl_ack    = gl_ack_q;
    assign gl_rdata  = gl_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_tile_map_arbiter.sv
// Scoreboard bench for tile_map_arbiter: stimulus pushes timed expectations, a negedge monitor checks them.
module tb_tile_map_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned TW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          p_tick = 1'b0;
    logic          display_on = 1'b0;
    logic [9:0]    x_pos = '0;
    logic [9:0]    y_pos = '0;
    logic [TW-1:0] tile_q;
    logic          tile_vld;
    logic          gl_req = 1'b0;
    logic          gl_we = 1'b0;
    logic [AW-1:0] gl_addr = '0;
    logic [TW-1:0] gl_wdata = '0;
    logic          gl_ack;
    logic [TW-1:0] gl_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [TW-1:0] mem_wdata;
    logic [TW-1:0] mem_rdata;
    logic [1:0]    err;

    tile_map_arbiter dut (
        .clk(clk), .rst(rst), .p_tick(p_tick), .display_on(display_on),
        .x_pos(x_pos), .y_pos(y_pos), .tile_q(tile_q), .tile_vld(tile_vld),
        .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr), .gl_wdata(gl_wdata),
        .gl_ack(gl_ack), .gl_rdata(gl_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    // Single-port RAM, 1-cycle read latency; unwritten cells read as their address mod 16.
    logic [TW-1:0] ram [512];
    bit            ram_set [512];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            ram_set[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_set[mem_addr] ? ram[mem_addr] : TW'(mem_addr);
    end

    typedef struct {
        int cyc;
        int val;
        bit chk;
    } exp_t;

    exp_t q_tile[$], q_gl[$], q_wr[$], q_addr[$], q_err[$];
    exp_t e;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int tmo_events = 0;
    int tmo_seen = 0;
    bit done = 1'b0;
    bit rst_prev = 1'b0;
    logic [TW-1:0] shadow [512];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: the only process that compares and counts.
    always @(negedge clk) begin
        if (tmo_events != tmo_seen) begin
            tmo_seen++;
            check("ack_timeout", 0, 1);
        end
        if (!rst) begin
            if (!rst_prev) begin
                check("reset_outputs", int'({tile_q, tile_vld, gl_ack, gl_rdata, mem_addr,
                                             mem_we, mem_wdata, err}), 0);
            end
        end else begin
            while (q_tile.size() > 0 && q_tile[0].cyc < cyc) begin
                e = q_tile.pop_front();
                check("tile_missing", 0, 1);
            end
            if (tile_vld) begin
                if (q_tile.size() == 0) check("tile_unexpected", 1, 0);
                else begin
                    e = q_tile.pop_front();
                    check("tile_cycle", cyc, e.cyc);
                    check("tile_q", int'(tile_q), e.val);
                end
            end
            while (q_gl.size() > 0 && q_gl[0].cyc < cyc) begin
                e = q_gl.pop_front();
                check("ack_missing", 0, 1);
            end
            if (gl_ack) begin
                if (q_gl.size() == 0) check("ack_unexpected", 1, 0);
                else begin
                    e = q_gl.pop_front();
                    check("ack_cycle", cyc, e.cyc);
                    if (e.chk) check("gl_rdata", int'(gl_rdata), e.val);
                end
            end
            while (q_wr.size() > 0 && q_wr[0].cyc < cyc) begin
                e = q_wr.pop_front();
                check("write_missing", 0, 1);
            end
            if (mem_we) begin
                if (q_wr.size() == 0) check("write_unexpected", 1, 0);
                else begin
                    e = q_wr.pop_front();
                    check("write_cycle", cyc, e.cyc);
                    check("write_addr_data", int'({mem_addr, mem_wdata}), e.val);
                end
            end
            while (q_addr.size() > 0 && q_addr[0].cyc <= cyc) begin
                e = q_addr.pop_front();
                if (e.cyc == cyc) check("mem_addr_we", int'({mem_we, mem_addr}), e.val);
                else check("addr_stale", e.cyc, cyc);
            end
            while (q_err.size() > 0 && q_err[0].cyc <= cyc) begin
                e = q_err.pop_front();
                if (e.cyc == cyc) check("err", int'(err), e.val);
                else check("err_stale", e.cyc, cyc);
            end
        end
        rst_prev = rst;
        if (done) begin
            check("queues_drained", q_tile.size() + q_gl.size() + q_wr.size() + q_addr.size()
                  + q_err.size(), 0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        bit         don;
        bit         slot;
    } vid_t;

    // Pushes expectations for a render slot issued in the current cycle.
    task automatic render_slot();
        int idx;
        idx = (int'(y_pos) >> 5) * 20 + (int'(x_pos) >> 5);
        q_addr.push_back('{cyc + 1, idx, 1'b1});
        q_tile.push_back('{cyc + 3, int'(shadow[idx]), 1'b1});
    endtask

    task automatic issue(input bit we, input int addr, input int wd);
        gl_req   = 1'b1;
        gl_we    = we;
        gl_addr  = AW'(addr);
        gl_wdata = TW'(wd);
    endtask

    task automatic wait_ack(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            p_tick = 1'b0;
            if (gl_ack) begin
                gl_req = 1'b0;
                return;
            end
        end
        gl_req = 1'b0;
        tmo_events++;
    endtask

    vid_t vids[6];

    initial begin
        for (int i = 0; i < 512; i++) shadow[i] = TW'(i);
        vids[0] = '{10'h040, 10'h020, 1'b1, 1'b1};
        vids[1] = '{10'h27F, 10'h1DF, 1'b1, 1'b1};
        vids[2] = '{10'h280, 10'h000, 1'b1, 1'b0};
        vids[3] = '{10'h000, 10'h1E0, 1'b1, 1'b0};
        vids[4] = '{10'h040, 10'h020, 1'b0, 1'b0};
        vids[5] = '{10'h000, 10'h000, 1'b1, 1'b1};

        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            p_tick     = 1'($urandom);
            display_on = 1'($urandom);
            x_pos      = 10'($urandom);
            y_pos      = 10'($urandom);
            gl_req     = 1'($urandom);
            gl_we      = 1'($urandom);
            gl_addr    = AW'($urandom);
            gl_wdata   = TW'($urandom);
        end
        @(negedge clk);
        p_tick = 0; gl_req = 0; gl_we = 0; gl_addr = '0; gl_wdata = '0;
        display_on = 1; x_pos = 10'h040; y_pos = 10'h020;
        rst = 1'b1;

        // Render slots every 4th cycle at tile (2,1) -> index 22.
        repeat (3) begin
            @(negedge clk);
            p_tick = 1'b1;
            render_slot();
            @(negedge clk);
            p_tick = 1'b0;
            repeat (2) @(negedge clk);
        end

        // Slot qualification at map edges and with display off.
        foreach (vids[i]) begin
            @(negedge clk);
            x_pos = vids[i].x; y_pos = vids[i].y; display_on = vids[i].don; p_tick = 1'b1;
            if (vids[i].slot) render_slot();
            @(negedge clk);
            p_tick = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        // Write 299 <- 0xA, then read it back.
        display_on = 1'b0;
        @(negedge clk);
        issue(1'b1, 299, 10);
        q_wr.push_back('{cyc + 1, 299 * 16 + 10, 1'b1});
        q_gl.push_back('{cyc + 2, 0, 1'b0});
        shadow[299] = 4'hA;
        wait_ack(10);
        @(negedge clk);
        issue(1'b0, 299, 0);
        q_addr.push_back('{cyc + 1, 299, 1'b1});
        q_gl.push_back('{cyc + 3, 10, 1'b1});
        wait_ack(10);

        // Render slot and game read in the same cycle.
        @(negedge clk);
        display_on = 1'b1; x_pos = 10'h040; y_pos = 10'h020; p_tick = 1'b1;
        render_slot();
        issue(1'b0, 5, 0);
        q_addr.push_back('{cyc + 2, 5, 1'b1});
        q_gl.push_back('{cyc + 4, int'(shadow[5]), 1'b1});
        wait_ack(10);

        // Out-of-range address.
        @(negedge clk);
        display_on = 1'b0;
        issue(1'b0, 300, 0);
        q_gl.push_back('{cyc + 1, 0, 1'b1});
        q_err.push_back('{cyc + 1, 2, 1'b1});
        wait_ack(10);

        // Reset while a read is in flight, then re-issue.
        @(negedge clk);
        issue(1'b0, 10, 0);
        @(negedge clk);
        rst = 1'b0;
        gl_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(1'b0, 10, 0);
        q_addr.push_back('{cyc + 1, 10, 1'b1});
        q_gl.push_back('{cyc + 3, int'(shadow[10]), 1'b1});
        wait_ack(10);

`ifdef BLANK_ONLY_WR_EN
        @(negedge clk);
        display_on = 1'b1;
        issue(1'b1, 7, 3);
        repeat (69) @(negedge clk);
        q_err.push_back('{cyc + 1, 1, 1'b1});
        @(negedge clk);
        display_on = 1'b0;
        q_wr.push_back('{cyc + 1, 7 * 16 + 3, 1'b1});
        q_gl.push_back('{cyc + 2, 0, 1'b0});
        wait_ack(10);
`else
        @(negedge clk);
        display_on = 1'b1;
        issue(1'b1, 7, 3);
        q_wr.push_back('{cyc + 1, 7 * 16 + 3, 1'b1});
        q_gl.push_back('{cyc + 2, 0, 1'b0});
        q_err.push_back('{cyc + 1, 0, 1'b1});
        wait_ack(10);
`endif
        shadow[7] = 4'h3;
        @(negedge clk);
        display_on = 1'b0;
        issue(1'b0, 7, 0);
        q_gl.push_back('{cyc + 3, 3, 1'b1});
        wait_ack(10);

        repeat (6) @(negedge clk);
        done = 1'b1;
        repeat (4) @(negedge clk);
    end

endmodule
